// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - writeback packet type, requester indices and arbiter defaults
package cdb_arbiter_pkg;

  localparam int ROB_TAG_W        = 6;
  localparam int PREG_W           = 7;
  localparam int XLEN             = 32;
  localparam int CDB_PORTS        = 2;
  localparam int CDB_NUM_REQ      = 4;
  localparam int CDB_STARVE_LIMIT = 8;
  localparam int CDB_STARVE_W     = 4;

  localparam logic [1:0] CDB_REQ_ALU0 = 2'd0;
  localparam logic [1:0] CDB_REQ_ALU1 = 2'd1;
  localparam logic [1:0] CDB_REQ_MDU  = 2'd2;
  localparam logic [1:0] CDB_REQ_DMEM = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    dest_preg;
    logic [XLEN-1:0]      data;
  } writeback_packet_t;

  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer results, grants and CDB broadcast ports
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  writeback_packet_t alu_result0;
  writeback_packet_t alu_result1;
  writeback_packet_t mdu_result;
  writeback_packet_t dcache_result;
  logic              alu_cdb_gnt0;
  logic              alu_cdb_gnt1;
  logic              mdu_cdb_gnt;
  logic              dcache_cdb_gnt;
  writeback_packet_t cdb_port0;
  writeback_packet_t cdb_port1;

  modport master (
    output alu_result0, alu_result1, mdu_result, dcache_result,
    input  alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt,
    input  cdb_port0, cdb_port1
  );

  modport slave (
    input  alu_result0, alu_result1, mdu_result, dcache_result,
    output alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt,
    output cdb_port0, cdb_port1
  );

endinterface

// File: rtl/cdb_rr_pick2.sv
// rtl/cdb_rr_pick2.sv - picks up to two requesters: forced index first, then rotation from ptr
module cdb_rr_pick2 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [1:0] force_idx,
  input  logic       force_val,
  output logic [3:0] win0,
  output logic [3:0] win1,
  output logic       win0_val,
  output logic       win1_val
);

  logic [1:0] idx;

  always_comb begin
    win0     = '0;
    win1     = '0;
    win0_val = 1'b0;
    win1_val = 1'b0;
    idx      = '0;
    if (force_val && req[force_idx]) begin
      win0[force_idx] = 1'b1;
      win0_val        = 1'b1;
    end
    // The forced requester already holds first place, so skip it in the rotation.
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && !(force_val && (idx == force_idx))) begin
        if (!win0_val) begin
          win0[idx] = 1'b1;
          win0_val  = 1'b1;
        end else if (!win1_val) begin
          win1[idx] = 1'b1;
          win1_val  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-port CDB arbiter: same-cycle grants, registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = CDB_NUM_REQ,
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT,
  parameter int STARVE_W     = CDB_STARVE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  cdb
);

  writeback_packet_t   result [NUM_REQ];
  writeback_packet_t   pkt0;
  writeback_packet_t   pkt1;
  writeback_packet_t   port0_q;
  writeback_packet_t   port1_q;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  starved;
  logic [NUM_REQ-1:0]  win0;
  logic [NUM_REQ-1:0]  win1;
  logic [NUM_REQ-1:0]  gnt;
  logic                win0_val;
  logic                win1_val;
  logic                gnt_en;
  logic                force_val;
  logic [1:0]          force_idx;
  logic [1:0]          win0_idx;
  logic [1:0]          win1_idx;
  logic [1:0]          prio_ptr;
  logic [STARVE_W-1:0] starve_cnt [NUM_REQ];

  assign result[CDB_REQ_ALU0] = cdb.alu_result0;
  assign result[CDB_REQ_ALU1] = cdb.alu_result1;
  assign result[CDB_REQ_MDU]  = cdb.mdu_result;
  assign result[CDB_REQ_DMEM] = cdb.dcache_result;

  always_comb begin
    req     = '0;
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]     = result[i].valid;
      starved[i] = result[i].valid && (starve_cnt[i] == STARVE_W'(STARVE_LIMIT));
    end
  end

  // Descending scan so the lowest-index starved requester is the one that sticks.
  always_comb begin
    force_val = 1'b0;
    force_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (starved[i]) begin
        force_val = 1'b1;
        force_idx = 2'(i);
      end
    end
  end

  cdb_rr_pick2 u_pick (
    .req       (req),
    .ptr       (prio_ptr),
    .force_idx (force_idx),
    .force_val (force_val),
    .win0      (win0),
    .win1      (win1),
    .win0_val  (win0_val),
    .win1_val  (win1_val)
  );

  assign win0_idx = onehot4_to_idx(win0);
  assign win1_idx = onehot4_to_idx(win1);
  assign gnt_en   = rst && !flush;
  assign gnt      = (win0 | win1) & {NUM_REQ{gnt_en}};

  assign cdb.alu_cdb_gnt0   = gnt[CDB_REQ_ALU0];
  assign cdb.alu_cdb_gnt1   = gnt[CDB_REQ_ALU1];
  assign cdb.mdu_cdb_gnt    = gnt[CDB_REQ_MDU];
  assign cdb.dcache_cdb_gnt = gnt[CDB_REQ_DMEM];

  always_comb begin
    pkt0 = '0;
    pkt1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win0[i]) pkt0 = result[i];
      if (win1[i]) pkt1 = result[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port0_q  <= '0;
      port1_q  <= '0;
      prio_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else if (flush) begin
      port0_q <= '0;
      port1_q <= '0;
    end else begin
      port0_q <= pkt0;
      port1_q <= pkt1;
      if (win1_val) begin
        prio_ptr <= win1_idx + 2'd1;
      end else if (win0_val) begin
        prio_ptr <= win0_idx + 2'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] || !req[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != STARVE_W'(STARVE_LIMIT)) begin
          starve_cnt[i] <= starve_cnt[i] + STARVE_W'(1);
        end
      end
    end
  end

  assign cdb.cdb_port0 = port0_q;
  assign cdb.cdb_port1 = port1_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct {
    writeback_packet_t p0;
    writeback_packet_t p1;
  } exp_t;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              flush = 1'b0;
  int                n_vec  = 0;
  int                n_miss = 0;
  int                seq_no = 0;
  writeback_packet_t pkt [4];
  logic [3:0]        gnt;
  int                m_ptr;
  int                m_cnt [4];
  bit                m_force;
  exp_t              sb [$];

  always #5 clk = ~clk;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .cdb   (bus)
  );

  assign bus.alu_result0   = pkt[0];
  assign bus.alu_result1   = pkt[1];
  assign bus.mdu_result    = pkt[2];
  assign bus.dcache_result = pkt[3];
  assign gnt = {bus.dcache_cdb_gnt, bus.mdu_cdb_gnt, bus.alu_cdb_gnt1, bus.alu_cdb_gnt0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic writeback_packet_t mk(input logic v, input int tag, input logic [31:0] d);
    writeback_packet_t p;
    p.valid     = v;
    p.rob_tag   = 6'(tag);
    p.dest_preg = 7'(tag + 3);
    p.data      = d;
    return p;
  endfunction

  // Reference order: starved+valid lowest index first, then rotation from the pointer.
  task automatic model_pick(output logic [3:0] g, output int w0, output int w1);
    int order [$];
    int first;
    int p;
    g = '0; w0 = -1; w1 = -1; first = -1;
    p = m_force ? 0 : m_ptr;
    if (flush || !rst) return;
    for (int i = 0; i < 4; i++)
      if (first < 0 && pkt[i].valid && m_cnt[i] == CDB_STARVE_LIMIT) first = i;
    if (first >= 0) order.push_back(first);
    for (int k = 0; k < 4; k++)
      if ((p + k) % 4 != first) order.push_back((p + k) % 4);
    foreach (order[j]) begin
      if (pkt[order[j]].valid) begin
        if (w0 < 0) w0 = order[j];
        else if (w1 < 0) w1 = order[j];
      end
    end
    if (w0 >= 0) g[w0] = 1'b1;
    if (w1 >= 0) g[w1] = 1'b1;
  endtask

  task automatic cycle(output logic [3:0] ag);
    logic [3:0] eg;
    int         w0, w1;
    exp_t       e, o;
    #2;
    model_pick(eg, w0, w1);
    ag = gnt;
    check("gnt", 64'(gnt), 64'(eg));
    e.p0 = '0;
    e.p1 = '0;
    if (w0 >= 0) e.p0 = pkt[w0];
    if (w1 >= 0) e.p1 = pkt[w1];
    sb.push_back(e);
    if (rst && !flush) begin
      if (w1 >= 0) m_ptr = (w1 + 1) % 4;
      else if (w0 >= 0) m_ptr = (w0 + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (eg[i] || !pkt[i].valid) m_cnt[i] = 0;
        else if (m_cnt[i] < CDB_STARVE_LIMIT) m_cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check("port0", 64'(bus.cdb_port0), 64'(o.p0));
    check("port1", 64'(bus.cdb_port1), 64'(o.p1));
  endtask

  task automatic refill(input logic [3:0] g, input int pct_valid, input logic [3:0] en);
    for (int i = 0; i < 4; i++) begin
      if (en[i] && (g[i] || !pkt[i].valid)) begin
        seq_no++;
        pkt[i] = mk(int'($urandom_range(99)) < pct_valid, seq_no, $urandom);
      end
    end
  endtask

  task automatic do_reset();
    flush   = 1'b0;
    rst     = 1'b0;
    m_ptr   = 0;
    m_force = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    sb.delete();
    #2;
    check("rst_gnt", 64'(gnt), 64'(0));
    @(posedge clk);
    #1;
    check("rst_p0v", 64'(bus.cdb_port0.valid), 64'(0));
    check("rst_p1v", 64'(bus.cdb_port1.valid), 64'(0));
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0]        ag;
    writeback_packet_t d;

    // Reset with every producer valid, then the first grants go to alu0/alu1.
    for (int i = 0; i < 4; i++) pkt[i] = mk(1'b1, 10 + i, 32'h1000 + i);
    do_reset();
    cycle(ag);
    check("rst_first", 64'(ag), 64'(4'b0011));

    // Lone mdu request.
    do_reset();
    for (int i = 0; i < 4; i++) pkt[i] = '0;
    pkt[2] = mk(1'b1, 5, 32'h0000_DEAD);
    cycle(ag);
    check("mdu_gnt", 64'(ag), 64'(4'b0100));
    check("mdu_tag", 64'(bus.cdb_port0.rob_tag), 64'(5));
    check("mdu_data", 64'(bus.cdb_port0.data), 64'(32'h0000_DEAD));
    check("mdu_p1v", 64'(bus.cdb_port1.valid), 64'(0));
    pkt[2] = '0;

    // Round-robin with all four continuously valid.
    do_reset();
    for (int i = 0; i < 4; i++) pkt[i] = mk(1'b1, 20 + i, $urandom);
    for (int c = 0; c < 6; c++) begin
      cycle(ag);
      check("rr_pat", 64'(ag), 64'((c % 2 == 1) ? 4'b1100 : 4'b0011));
      refill(ag, 100, 4'hF);
    end

    // Asynchronous reset between edges while port0 holds a packet.
    check("async_pre", 64'(bus.cdb_port0.valid), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    check("async_p0v", 64'(bus.cdb_port0.valid), 64'(0));
    check("async_p1v", 64'(bus.cdb_port1.valid), 64'(0));
    check("async_gnt", 64'(gnt), 64'(0));
    do_reset();
    cycle(ag);
    check("resume0", 64'(ag), 64'(4'b0011));
    refill(ag, 100, 4'hF);

    // One-cycle flush with everyone valid.
    flush = 1'b1;
    cycle(ag);
    check("flush_gnt", 64'(ag), 64'(0));
    flush = 1'b0;
    check("flush_ptr", 64'(dut.prio_ptr), 64'(2));
    cycle(ag);
    check("flush_resume", 64'(ag), 64'(4'b1100));

    // Starvation: pointer pinned at alu0, dcache loses eight times then is forced in.
    do_reset();
    pkt[0] = mk(1'b1, 40, $urandom);
    pkt[1] = mk(1'b1, 41, $urandom);
    pkt[2] = '0;
    pkt[3] = mk(1'b1, 43, 32'hCAFE_0003);
    d      = pkt[3];
    force dut.prio_ptr = 2'd0;
    m_force = 1'b1;
    for (int c = 0; c < CDB_STARVE_LIMIT; c++) begin
      cycle(ag);
      check("starve_deny", 64'(ag[3]), 64'(0));
      refill(ag, 100, 4'b0011);
    end
    check("starve_cnt_sat", 64'(dut.starve_cnt[3]), 64'(CDB_STARVE_LIMIT));
    cycle(ag);
    check("starve_gnt", 64'(ag[3]), 64'(1));
    check("starve_p0", 64'(bus.cdb_port0), 64'(d));
    check("starve_clr", 64'(dut.starve_cnt[3]), 64'(0));
    release dut.prio_ptr;

    // Random traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 4; i++) pkt[i] = '0;
    refill(4'h0, 60, 4'hF);
    for (int c = 0; c < 60; c++) begin
      flush = ($urandom_range(9) == 0);
      cycle(ag);
      refill(ag, 60, 4'hF);
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
